// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latches one request, waits WAIT_CYCLES,
// commits against word storage and holds the response until it is taken.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic        commit;
  logic        addr_err;
  logic [AW-1:0] widx;

  assign widx     = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));

  // Next-state, request latching and response data selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
          err_d   = addr_err;
          // Rejected requests and writes both answer with zero data
          if (!addr_err && !wr_q) begin
            rdata_d = mem[widx];
          end else begin
            rdata_d = 32'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write
  always_ff @(posedge Clk) begin
    if (reset && commit && wr_q && !addr_err) begin
      mem[widx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == IDLE) && reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder: one instance with two wait
// states, one with none, both checked against a word-array reference model.
module tb_mem_responder;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  // instance A: WAIT_CYCLES=2
  logic        a_req_valid, a_req_ready, a_req_wr, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  // instance B: WAIT_CYCLES=0
  logic        b_req_valid, b_req_ready, b_req_wr, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .Clk(Clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .Clk(Clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference storage: value plus "has been written" flag per word, per instance
  logic [31:0] mdl_a [256];
  bit          known_a [256];
  logic [31:0] mdl_b [256];
  bit          known_b [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] addr);
    return (addr % 32'd4 != 32'd0) || (addr / 32'd4 >= 32'd256);
  endfunction

  // One transaction on A; hold = cycles to stall in RESP while spamming a new request
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rdata, output logic err);
    int k;
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = wdata;
    a_resp_ready = 1'b0;
    k = 0;
    while (!a_req_ready && k < 20) begin @(negedge Clk); k++; end
    chk("a_accept_ready", {31'd0, a_req_ready}, 32'd1);
    @(posedge Clk); #1;
    // scramble inputs after accept; the latched request must be used
    a_req_valid = 1'b0; a_req_wr = ~wr; a_req_addr = $urandom; a_req_wdata = $urandom;
    k = 0;
    while (!a_resp_valid && k < 40) begin @(posedge Clk); #1; k++; end
    chk("a_latency", 32'(k), 32'd3);
    chk("a_ready_in_resp", {31'd0, a_req_ready}, 32'd0);
    rdata = a_resp_rdata;
    err   = a_resp_err;
    a_req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      a_req_addr = $urandom_range(0, 255) * 4; a_req_wr = $urandom; a_req_wdata = $urandom;
      @(posedge Clk); #1;
      chk("a_hold_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("a_hold_rdata", a_resp_rdata, rdata);
      chk("a_hold_err", {31'd0, a_resp_err}, {31'd0, err});
      chk("a_hold_ready", {31'd0, a_req_ready}, 32'd0);
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(posedge Clk); #1;
    a_resp_ready = 1'b0;
    chk("a_done_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("a_done_rdata", a_resp_rdata, 32'd0);
    chk("a_done_err", {31'd0, a_resp_err}, 32'd0);
    if (hold > 0) begin
      repeat (5) begin
        @(posedge Clk); #1;
        chk("a_not_queued", {31'd0, a_resp_valid}, 32'd0);
      end
    end
  endtask

  // One transaction on B with resp_ready tied high
  task automatic txn_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
    int k;
    @(negedge Clk);
    b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_wdata = wdata;
    k = 0;
    while (!b_req_ready && k < 20) begin @(negedge Clk); k++; end
    chk("b_accept_ready", {31'd0, b_req_ready}, 32'd1);
    @(posedge Clk); #1;
    b_req_valid = 1'b0; b_req_addr = $urandom; b_req_wdata = $urandom;
    k = 0;
    while (!b_resp_valid && k < 40) begin @(posedge Clk); #1; k++; end
    chk("b_latency", 32'(k), 32'd1);
    rdata = b_resp_rdata;
    err   = b_resp_err;
    @(posedge Clk); #1;
    chk("b_done_valid", {31'd0, b_resp_valid}, 32'd0);
  endtask

  // Check a response against the model and update the model for valid writes
  task automatic check_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input string tag);
    bit e;
    e = exp_err(addr);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    if (e || wr) chk({tag, "_rdata0"}, rdata, 32'd0);
    else if (known_a[addr[9:2]]) chk({tag, "_rdata"}, rdata, mdl_a[addr[9:2]]);
    if (wr && !e) begin mdl_a[addr[9:2]] = wdata; known_a[addr[9:2]] = 1'b1; end
  endtask

  task automatic check_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input string tag);
    bit e;
    e = exp_err(addr);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    if (e || wr) chk({tag, "_rdata0"}, rdata, 32'd0);
    else if (known_b[addr[9:2]]) chk({tag, "_rdata"}, rdata, mdl_b[addr[9:2]]);
    if (wr && !e) begin mdl_b[addr[9:2]] = wdata; known_b[addr[9:2]] = 1'b1; end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 32'($urandom_range(0, 15)) * 32'd4;
    else if (sel == 7) return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
    else if (sel == 8) return 32'($urandom_range(256, 300)) * 32'd4;
    else               return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        wr;
    logic [31:0] ad, wd;
    int k;

    reset = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin known_a[i] = 1'b0; known_b[i] = 1'b0; end

    // reset state, with a request offered during reset
    a_req_valid = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_rdata", a_resp_rdata, 32'd0);
    chk("rst_err", {31'd0, a_resp_err}, 32'd0);
    a_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst_ready", {31'd0, a_req_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, a_resp_valid}, 32'd0);

    // write then read back at 0x10
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er); check_a(1'b1, 32'h10, 32'hDEADBEEF, rd, er, "wr10");
    txn_a(1'b0, 32'h10, 32'd0, 0, rd, er);        check_a(1'b0, 32'h10, 32'd0, rd, er, "rd10");
    chk("rd10_direct", rd, 32'hDEADBEEF);

    // error cases leave word 0 intact
    txn_a(1'b1, 32'h0, 32'hA5A5_0001, 0, rd, er); check_a(1'b1, 32'h0, 32'hA5A5_0001, rd, er, "wr0");
    txn_a(1'b1, 32'h1, 32'hBAD0_0001, 0, rd, er); check_a(1'b1, 32'h1, 32'hBAD0_0001, rd, er, "wr_mis");
    txn_a(1'b1, 32'h400, 32'hBAD0_0002, 0, rd, er); check_a(1'b1, 32'h400, 32'hBAD0_0002, rd, er, "wr_oor");
    txn_a(1'b0, 32'h13, 32'd0, 0, rd, er);        check_a(1'b0, 32'h13, 32'd0, rd, er, "rd_mis");
    txn_a(1'b0, 32'h400, 32'd0, 0, rd, er);       check_a(1'b0, 32'h400, 32'd0, rd, er, "rd_oor");
    txn_a(1'b0, 32'h3FC, 32'd0, 0, rd, er);       check_a(1'b0, 32'h3FC, 32'd0, rd, er, "rd_last");
    txn_a(1'b0, 32'h0, 32'd0, 0, rd, er);         check_a(1'b0, 32'h0, 32'd0, rd, er, "rd0");
    chk("rd0_direct", rd, 32'hA5A5_0001);

    // stall in RESP with a competing request
    txn_a(1'b0, 32'h10, 32'd0, 5, rd, er);        check_a(1'b0, 32'h10, 32'd0, rd, er, "stall");

    // reset during WAIT aborts the write
    txn_a(1'b1, 32'h20, 32'h0BAD_F00D, 0, rd, er); check_a(1'b1, 32'h20, 32'h0BAD_F00D, rd, er, "wr20_old");
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h12345678;
    @(posedge Clk); #1;
    a_req_valid = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    @(posedge Clk); #1;
    chk("wait_rst_ready", {31'd0, a_req_ready}, 32'd0);
    reset = 1'b1;
    k = 0;
    repeat (6) begin @(posedge Clk); #1; if (a_resp_valid) k++; end
    chk("aborted_no_resp", 32'(k), 32'd0);
    txn_a(1'b0, 32'h20, 32'd0, 0, rd, er);        check_a(1'b0, 32'h20, 32'd0, rd, er, "rd20_old");
    chk("rd20_old_direct", rd, 32'h0BAD_F00D);

    // completed write survives a later reset
    txn_a(1'b1, 32'h20, 32'h12345678, 0, rd, er); check_a(1'b1, 32'h20, 32'h12345678, rd, er, "wr20_new");
    @(negedge Clk); reset = 1'b0;
    @(negedge Clk); reset = 1'b1;
    txn_a(1'b0, 32'h20, 32'd0, 0, rd, er);        check_a(1'b0, 32'h20, 32'd0, rd, er, "rd20_new");
    chk("rd20_new_direct", rd, 32'h12345678);

    // zero-wait instance: back-to-back write/read at 0xFC
    txn_b(1'b1, 32'hFC, 32'hCAFE_0123, rd, er);  check_b(1'b1, 32'hFC, 32'hCAFE_0123, rd, er, "b_wrfc");
    txn_b(1'b0, 32'hFC, 32'd0, rd, er);          check_b(1'b0, 32'hFC, 32'd0, rd, er, "b_rdfc");
    chk("b_rdfc_direct", rd, 32'hCAFE_0123);

    // randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      wr = $urandom; ad = rand_addr(); wd = $urandom;
      txn_a(wr, ad, wd, ($urandom_range(0, 7) == 0) ? 2 : 0, rd, er);
      check_a(wr, ad, wd, rd, er, "rand_a");
      wr = $urandom; ad = rand_addr(); wd = $urandom;
      txn_b(wr, ad, wd, rd, er);
      check_b(wr, ad, wd, rd, er, "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two, 4..4096).
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request accept and response (0..15).
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The module SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The module SHALL have port req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 The module SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The module SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 The module SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-011 The module SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 The module SHALL have port resp_rdata, output, 32 bits: read data.
REQ-013 The module SHALL have port resp_err, output, 1 bit: the request was rejected (misaligned or out of range).

Function
REQ-014 The module SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, resp_valid = 1 only in RESP.
REQ-015 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; req_wr, req_addr and req_wdata are latched on that edge, and later input changes have no effect.
REQ-016 On accept, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES, or go directly to the commit step if WAIT_CYCLES=0.
REQ-017 In WAIT, the counter SHALL decrement once per cycle; the commit step occurs on the edge where the counter reaches 0, and the FSM enters RESP on that edge.
REQ-018 Latency: with accept on edge t, resp_valid SHALL first be high in the cycle after edge t+1+WAIT_CYCLES (WAIT_CYCLES=0 gives resp_valid one cycle after accept).
REQ-019 Error check: resp_err SHALL be 1 if latched addr[1:0] != 0, or if addr[31:2] >= DEPTH_WORDS.
REQ-020 An erroring request SHALL NOT modify storage, and its resp_rdata SHALL be 0.
REQ-021 Commit for a valid write SHALL store wdata at word addr[31:2]; resp_rdata for a write SHALL be 0.
REQ-022 Commit for a valid read SHALL capture the word at addr[31:2] into resp_rdata.
REQ-023 In RESP, resp_rdata and resp_err SHALL stay stable until resp_ready=1.
REQ-024 On a cycle with resp_valid=1 and resp_ready=1, the FSM SHALL return to IDLE; the next request can be accepted no earlier than the following cycle.
REQ-025 At most one request SHALL be outstanding; req_valid during WAIT or RESP is ignored and not queued.
REQ-026 A read after a completed write to the same word SHALL return the written data.
REQ-027 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-028 When reset=0 at a rising edge, the FSM SHALL go to IDLE, the wait counter and latched request SHALL clear to 0, and outputs SHALL be req_ready=1 (from the next cycle), resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 Reset SHALL NOT clear storage contents; storage power-up contents are undefined.
REQ-030 A reset in WAIT SHALL abort the request without committing it; a write already committed (RESP reached) SHALL remain in storage.
REQ-031 While reset=0, req_ready SHALL be 0 and no request is accepted.

Verification
REQ-032 Bench: WAIT_CYCLES=2; write 0xDEADBEEF to 0x10 accepted at edge t -> resp_valid high after edge t+3, resp_err=0, resp_rdata=0; then a read of 0x10 -> resp_rdata=0xDEADBEEF.
REQ-033 Bench: read of addr 0x13 (misaligned) and of 0x400 with DEPTH_WORDS=256 -> resp_err=1, resp_rdata=0; a prior value at word 0 is unchanged.
REQ-034 Bench: hold resp_ready=0 for 5 cycles in RESP while driving req_valid=1 with new addr -> resp_rdata/resp_err stable, req_ready=0, second request not accepted.
REQ-035 Bench: WAIT_CYCLES=0 back-to-back write/read at 0xFC with resp_ready tied 1 -> each response one cycle after accept; read returns written data.
REQ-036 Bench: write 0x12345678 to 0x20, assert reset=0 during WAIT -> no response; after reset, read 0x20 returns the old value; a reset after resp_valid leaves the new value.
